// File: rtl/hall_emulator.sv
// Three-phase Hall sensor sequence generator with programmable sector period and direction.
// Optional HALL_FAULT_INJECT_EN adds FAULT_INJ, which forces the registered Hall code to 000.
module hall_emulator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIR,
    input  logic [CNT_W-1:0] STEP_PERIOD,
`ifdef HALL_FAULT_INJECT_EN
    input  logic             FAULT_INJ,
`endif
    output logic             H1,
    output logic             H2,
    output logic             H3,
    output logic             STEP,
    output logic [2:0]       SECTOR
);

    typedef enum logic [2:0] {
        SEC0 = 3'd0,
        SEC1 = 3'd1,
        SEC2 = 3'd2,
        SEC3 = 3'd3,
        SEC4 = 3'd4,
        SEC5 = 3'd5
    } sector_e;

    sector_e          sector_q, sector_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [2:0]       h_q, h_d;
    logic [CNT_W-1:0] period_m1;
    logic             advance;
    logic             fault;

`ifdef HALL_FAULT_INJECT_EN
    assign fault = FAULT_INJ;
`else
    assign fault = 1'b0;
`endif

    function automatic logic [2:0] sector_code(input sector_e s);
        logic [2:0] code;
        code = 3'b100;
        unique case (s)
            SEC0:    code = 3'b100;
            SEC1:    code = 3'b101;
            SEC2:    code = 3'b001;
            SEC3:    code = 3'b011;
            SEC4:    code = 3'b010;
            SEC5:    code = 3'b110;
            default: code = 3'b100;
        endcase
        return code;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            sector_q <= SEC0;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            h_q      <= 3'b100;
        end else begin
            sector_q <= sector_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            h_q      <= h_d;
        end
    end

    // A zero period behaves as one; the >= compare lets a lowered period take effect at once.
    always_comb begin
        period_m1 = (STEP_PERIOD == '0) ? '0 : STEP_PERIOD - CNT_W'(1);
        advance   = EN && (cnt_q >= period_m1);
        sector_d  = sector_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        if (advance) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (!DIR) begin
                unique case (sector_q)
                    SEC0:    sector_d = SEC1;
                    SEC1:    sector_d = SEC2;
                    SEC2:    sector_d = SEC3;
                    SEC3:    sector_d = SEC4;
                    SEC4:    sector_d = SEC5;
                    SEC5:    sector_d = SEC0;
                    default: sector_d = SEC0;
                endcase
            end else begin
                unique case (sector_q)
                    SEC0:    sector_d = SEC5;
                    SEC1:    sector_d = SEC0;
                    SEC2:    sector_d = SEC1;
                    SEC3:    sector_d = SEC2;
                    SEC4:    sector_d = SEC3;
                    SEC5:    sector_d = SEC4;
                    default: sector_d = SEC0;
                endcase
            end
        end else if (EN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Hall code is registered from the next sector so H and SECTOR change on the same edge.
    always_comb begin
        h_d = fault ? 3'b000 : sector_code(sector_d);
    end

    assign H1     = h_q[2];
    assign H2     = h_q[1];
    assign H3     = h_q[0];
    assign STEP   = step_q;
    assign SECTOR = sector_q;

endmodule
